rx78_kbd_matrix: RTL and testbench

RX78_KBD_MATRIX -- requirements
Module: rx78_kbd_matrix

---
 rtl/rx78_pkg.sv | 31 +++
 rtl/rx78_kbd_decode.sv | 112 +++++++++++
 rtl/rx78_kbd_matrix.sv | 91 +++++++++
 tb/tb_rx78_kbd_matrix.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx78_pkg.sv
// Shared constants and types for the RX-78 keyboard/joystick matrix.
// The decode struct carries one scancode event through the two-stage update pipeline.
package rx78_pkg;

    localparam int KBD_ROWS = 9;
    localparam int KBD_COLS = 8;

    localparam logic [3:0] JOY1_ROW = 4'd9;
    localparam logic [3:0] JOY2_ROW = 4'd10;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
        logic       press;
    } kbd_dec_t;

    // Joystick rows present the six button bits in their native order, top two bits zero.
    function automatic logic [7:0] joy_row(input logic [5:0] j);
        return {2'b00, j[JOY_FIRE2], j[JOY_FIRE1], j[JOY_UP],
                j[JOY_DOWN], j[JOY_LEFT], j[JOY_RIGHT]};
    endfunction

endpackage

// File: rtl/rx78_kbd_decode.sv
// Combinational PS/2 set-2 scancode lookup: {extended, code} -> matrix row/column.
// Anything not listed decodes as invalid and never touches the matrix.
import rx78_pkg::*;

module rx78_kbd_decode (
    input  logic       i_ext,
    input  logic [7:0] i_code,
    output logic       o_valid,
    output logic [3:0] o_row,
    output logic [2:0] o_col
);

    logic [6:0] w_pos;
    logic       w_hit;

    always_comb begin
        w_hit = 1'b1;
        w_pos = 7'd0;
        case ({i_ext, i_code})
            // row 0: digits 0-7
            9'h045: w_pos = {4'd0, 3'd0};
            9'h016: w_pos = {4'd0, 3'd1};
            9'h01E: w_pos = {4'd0, 3'd2};
            9'h026: w_pos = {4'd0, 3'd3};
            9'h025: w_pos = {4'd0, 3'd4};
            9'h02E: w_pos = {4'd0, 3'd5};
            9'h036: w_pos = {4'd0, 3'd6};
            9'h03D: w_pos = {4'd0, 3'd7};
            // row 1: 8 9 - = ; ' , .
            9'h03E: w_pos = {4'd1, 3'd0};
            9'h046: w_pos = {4'd1, 3'd1};
            9'h04E: w_pos = {4'd1, 3'd2};
            9'h055: w_pos = {4'd1, 3'd3};
            9'h04C: w_pos = {4'd1, 3'd4};
            9'h052: w_pos = {4'd1, 3'd5};
            9'h041: w_pos = {4'd1, 3'd6};
            9'h049: w_pos = {4'd1, 3'd7};
            // row 2: / A-G
            9'h04A: w_pos = {4'd2, 3'd0};
            9'h01C: w_pos = {4'd2, 3'd1};
            9'h032: w_pos = {4'd2, 3'd2};
            9'h021: w_pos = {4'd2, 3'd3};
            9'h023: w_pos = {4'd2, 3'd4};
            9'h024: w_pos = {4'd2, 3'd5};
            9'h02B: w_pos = {4'd2, 3'd6};
            9'h034: w_pos = {4'd2, 3'd7};
            // row 3: H-O
            9'h033: w_pos = {4'd3, 3'd0};
            9'h043: w_pos = {4'd3, 3'd1};
            9'h03B: w_pos = {4'd3, 3'd2};
            9'h042: w_pos = {4'd3, 3'd3};
            9'h04B: w_pos = {4'd3, 3'd4};
            9'h03A: w_pos = {4'd3, 3'd5};
            9'h031: w_pos = {4'd3, 3'd6};
            9'h044: w_pos = {4'd3, 3'd7};
            // row 4: P-W
            9'h04D: w_pos = {4'd4, 3'd0};
            9'h015: w_pos = {4'd4, 3'd1};
            9'h02D: w_pos = {4'd4, 3'd2};
            9'h01B: w_pos = {4'd4, 3'd3};
            9'h02C: w_pos = {4'd4, 3'd4};
            9'h03C: w_pos = {4'd4, 3'd5};
            9'h02A: w_pos = {4'd4, 3'd6};
            9'h01D: w_pos = {4'd4, 3'd7};
            // row 5: X Y Z [ \ ] ` backspace
            9'h022: w_pos = {4'd5, 3'd0};
            9'h035: w_pos = {4'd5, 3'd1};
            9'h01A: w_pos = {4'd5, 3'd2};
            9'h054: w_pos = {4'd5, 3'd3};
            9'h05D: w_pos = {4'd5, 3'd4};
            9'h05B: w_pos = {4'd5, 3'd5};
            9'h00E: w_pos = {4'd5, 3'd6};
            9'h066: w_pos = {4'd5, 3'd7};
            // row 6: F1-F5, enter, esc, delete
            9'h005: w_pos = {4'd6, 3'd0};
            9'h006: w_pos = {4'd6, 3'd1};
            9'h004: w_pos = {4'd6, 3'd2};
            9'h00C: w_pos = {4'd6, 3'd3};
            9'h003: w_pos = {4'd6, 3'd4};
            9'h05A: w_pos = {4'd6, 3'd5};
            9'h076: w_pos = {4'd6, 3'd6};
            9'h171: w_pos = {4'd6, 3'd7};
            // row 7: both shifts share col 0, then modifiers and editing keys
            9'h012, 9'h059: w_pos = {4'd7, 3'd0};
            9'h014: w_pos = {4'd7, 3'd1};
            9'h011: w_pos = {4'd7, 3'd2};
            9'h058: w_pos = {4'd7, 3'd3};
            9'h16C: w_pos = {4'd7, 3'd4};
            9'h170: w_pos = {4'd7, 3'd5};
            9'h169: w_pos = {4'd7, 3'd6};
            9'h00D: w_pos = {4'd7, 3'd7};
            // row 8: space, cursor keys, page keys, right ctrl
            9'h029: w_pos = {4'd8, 3'd0};
            9'h174: w_pos = {4'd8, 3'd1};
            9'h16B: w_pos = {4'd8, 3'd2};
            9'h172: w_pos = {4'd8, 3'd3};
            9'h175: w_pos = {4'd8, 3'd4};
            9'h17D: w_pos = {4'd8, 3'd5};
            9'h17A: w_pos = {4'd8, 3'd6};
            9'h114: w_pos = {4'd8, 3'd7};
            default: begin
                w_hit = 1'b0;
                w_pos = 7'd0;
            end
        endcase
    end

    assign o_valid = w_hit;
    assign o_row   = w_pos[6:3];
    assign o_col   = w_pos[2:0];

endmodule

// File: rtl/rx78_kbd_matrix.sv
// PS/2 key events -> 9x8 keyboard matrix, plus two joystick rows, read back by row select.
// Pipeline: toggle detect + decode register, then matrix write, then registered column read.
import rx78_pkg::*;

module rx78_kbd_matrix (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joy1,
    input  logic [31:0] joy2,
    input  logic [3:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        any_key
);

    logic                          r_arm_pend;
    logic                          r_tog;
    kbd_dec_t                      r_dec;
    logic [KBD_ROWS-1:0][KBD_COLS-1:0] r_matrix;
    logic [7:0]                    r_col_data;
    logic                          r_any_key;

    logic       w_new_evt;
    logic       w_lut_valid;
    logic [3:0] w_lut_row;
    logic [2:0] w_lut_col;
    logic [7:0] w_col_next;
    logic       w_unused_joy;

    // The arm cycle after reset only learns the current toggle level, so a toggle
    // that happens to be 1 at reset release is not mistaken for a new event.
    assign w_new_evt = !r_arm_pend && (ps2_key[10] != r_tog);

    rx78_kbd_decode u_decode (
        .i_ext   (ps2_key[8]),
        .i_code  (ps2_key[7:0]),
        .o_valid (w_lut_valid),
        .o_row   (w_lut_row),
        .o_col   (w_lut_col)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_pend <= 1'b1;
            r_tog      <= 1'b0;
            r_dec      <= '0;
        end else begin
            r_arm_pend  <= 1'b0;
            r_tog       <= ps2_key[10];
            r_dec.valid <= w_new_evt && w_lut_valid;
            r_dec.row   <= w_lut_row;
            r_dec.col   <= w_lut_col;
            r_dec.press <= ps2_key[9];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_matrix <= '0;
        end else if (r_dec.valid) begin
            r_matrix[r_dec.row][r_dec.col] <= r_dec.press;
        end
    end

    always_comb begin
        w_col_next = 8'h00;
        if (row_sel < 4'(KBD_ROWS)) begin
            w_col_next = r_matrix[row_sel];
        end else if (row_sel == JOY1_ROW) begin
            w_col_next = joy_row(joy1[5:0]);
        end else if (row_sel == JOY2_ROW) begin
            w_col_next = joy_row(joy2[5:0]);
        end
    end

    assign w_unused_joy = ^{joy1[31:6], joy2[31:6]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col_data <= 8'h00;
            r_any_key  <= 1'b0;
        end else begin
            r_col_data <= w_col_next;
            r_any_key  <= |r_matrix;
        end
    end

    assign col_data = r_col_data;
    assign any_key  = r_any_key;

endmodule

// File: tb/tb_rx78_kbd_matrix.sv
// Bench for rx78_kbd_matrix: directed sequences, a vector table, and a randomized
// run against a key-position model with a one-event delay queue.
module tb_rx78_kbd_matrix;

    logic        clk;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joy1;
    logic [31:0] joy2;
    logic [3:0]  row_sel;
    logic [7:0]  col_data;
    logic        any_key;

    int n_cmp;
    int n_err;
    logic cur_tog;

    rx78_kbd_matrix dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .joy1     (joy1),
        .joy2     (joy2),
        .row_sel  (row_sel),
        .col_data (col_data),
        .any_key  (any_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       press;
        logic       ext;
        logic [7:0] code;
        logic [3:0] rs;
        logic [7:0] exp_col;
        logic       exp_any;
    } vec_t;

    typedef struct {
        logic       press;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    localparam int NV = 12;
    vec_t vt [NV];

    logic [7:0] mm [9];
    evt_t       evt_q [$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic press, input logic ext, input logic [7:0] code);
        cur_tog = ~cur_tog;
        ps2_key = {cur_tog, press, ext, code};
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    // Known key positions as row*8+col, -1 when the key has no place in the matrix.
    function automatic int ref_pos(input logic ext, input logic [7:0] code);
        if (!ext && code == 8'h1C) return 2 * 8 + 1;
        if (!ext && code == 8'h29) return 8 * 8 + 0;
        if ( ext && code == 8'h75) return 8 * 8 + 4;
        if (!ext && (code == 8'h12 || code == 8'h59)) return 7 * 8 + 0;
        return -1;
    endfunction

    function automatic logic [7:0] ref_col(input int rs, input logic [31:0] j1, input logic [31:0] j2);
        if (rs < 9)   return mm[rs];
        if (rs == 9)  return 8'(j1 & 32'h3F);
        if (rs == 10) return 8'(j2 & 32'h3F);
        return 8'h00;
    endfunction

    function automatic logic ref_any();
        logic a;
        a = 1'b0;
        for (int r = 0; r < 9; r++) a = a | (mm[r] != 8'h00);
        return a;
    endfunction

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cur_tog = 1'b1;
        reset   = 1'b1;
        ps2_key = 11'h400;
        joy1    = 32'h0;
        joy2    = 32'h0;
        row_sel = 4'd0;

        // Reset then arm with toggle held high through release.
        tick();
        check("reset col_data", col_data, 8'h00);
        check("reset any_key", any_key, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 16; r++) begin
            row_sel = 4'(r);
            tick();
            check($sformatf("arm row%0d", r), col_data, 8'h00);
        end
        check("arm any_key", any_key, 1'b0);

        // Press A: exact 3-cycle latency.
        row_sel = 4'd2;
        send(1'b1, 1'b0, 8'h1C);
        check("A lat1", col_data, 8'h00);
        tick();
        check("A lat2", col_data, 8'h00);
        tick();
        check("A lat3 col", col_data, 8'h02);
        check("A lat3 any", any_key, 1'b1);
        send(1'b0, 1'b0, 8'h1C);
        tick();
        tick();
        check("A rel col", col_data, 8'h00);
        check("A rel any", any_key, 1'b0);

        // Back-to-back events on consecutive cycles.
        row_sel = 4'd8;
        send(1'b1, 1'b0, 8'h29);
        send(1'b1, 1'b1, 8'h75);
        tick();
        tick();
        check("b2b row8", col_data, 8'h11);

        // Reset one cycle after a space-press toggle: event must be dropped.
        do_reset();
        row_sel = 4'd8;
        send(1'b1, 1'b0, 8'h29);
        reset = 1'b1;
        #1;
        check("midrst async col", col_data, 8'h00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("midrst row8", col_data, 8'h00);
        check("midrst any", any_key, 1'b0);

        // Vector table: one event, settle, read the selected row.
        vt[0]  = '{1'b1, 1'b0, 8'h1C, 4'd2, 8'h02, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 8'h1C, 4'd2, 8'h02, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 8'h29, 4'd8, 8'h00, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 8'h0F, 4'd2, 8'h02, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 8'h1C, 4'd2, 8'h00, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 8'h12, 4'd7, 8'h01, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 8'h59, 4'd7, 8'h01, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 8'h59, 4'd7, 8'h00, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 8'h59, 4'd7, 8'h01, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 8'h12, 4'd7, 8'h00, 1'b0};
        vt[10] = '{1'b1, 1'b1, 8'h75, 4'd8, 8'h10, 1'b1};
        vt[11] = '{1'b0, 1'b1, 8'h75, 4'd8, 8'h00, 1'b0};
        for (int i = 0; i < NV; i++) begin
            row_sel = vt[i].rs;
            send(vt[i].press, vt[i].ext, vt[i].code);
            tick();
            tick();
            check($sformatf("vec%0d col", i), col_data, vt[i].exp_col);
            check($sformatf("vec%0d any", i), any_key, vt[i].exp_any);
        end

        // Joystick rows: live inputs, upper bits ignored, unused rows zero.
        joy1 = 32'h13;
        joy2 = 32'h2C;
        row_sel = 4'd9;
        tick();
        check("joy1 row", col_data, 8'h13);
        row_sel = 4'd10;
        tick();
        check("joy2 row", col_data, 8'h2C);
        row_sel = 4'd12;
        tick();
        check("row12 zero", col_data, 8'h00);
        row_sel = 4'd9;
        joy1 = 32'hFFFF_FFC0;
        tick();
        check("joy1 upper ignored", col_data, 8'h00);
        joy1 = 32'h21;
        tick();
        check("joy1 live", col_data, 8'h21);

        // Randomized run against the model.
        do_reset();
        for (int r = 0; r < 9; r++) mm[r] = 8'h00;
        evt_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic       has_evt;
            evt_t       e;
            logic [7:0] exp_col;
            logic       exp_any;
            int         k;
            has_evt = 1'($urandom_range(0, 1));
            e.press = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 5);
            case (k)
                0: begin e.ext = 1'b0; e.code = 8'h1C; end
                1: begin e.ext = 1'b0; e.code = 8'h29; end
                2: begin e.ext = 1'b1; e.code = 8'h75; end
                3: begin e.ext = 1'b0; e.code = 8'h12; end
                4: begin e.ext = 1'b0; e.code = 8'h59; end
                default: begin e.ext = 1'b0; e.code = 8'h0F; end
            endcase
            if (has_evt) begin
                cur_tog = ~cur_tog;
                ps2_key = {cur_tog, e.press, e.ext, e.code};
            end else begin
                ps2_key = {cur_tog, 1'($urandom_range(0, 1)), e.ext, e.code};
            end
            row_sel = 4'($urandom_range(0, 15));
            joy1 = $urandom;
            joy2 = $urandom;
            exp_col = ref_col(int'(row_sel), joy1, joy2);
            exp_any = ref_any();
            if (evt_q.size() > 0) begin
                evt_t a;
                int   p;
                a = evt_q.pop_front();
                p = ref_pos(a.ext, a.code);
                if (p >= 0) mm[p / 8][p % 8] = a.press;
            end
            if (has_evt) evt_q.push_back(e);
            tick();
            check($sformatf("rnd%0d col rs%0d", c, row_sel), col_data, exp_col);
            check($sformatf("rnd%0d any", c), any_key, exp_any);
            if (!has_evt && evt_q.size() > 0) begin
                evt_t a;
                int   p;
                a = evt_q.pop_front();
                p = ref_pos(a.ext, a.code);
                if (p >= 0) mm[p / 8][p % 8] = a.press;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
